// File: rtl/instr_cache_if.sv
// Fetch and refill bus of the instruction cache. The cache is the slave.
// The fetch stage and the memory model sit on the master side.
interface instr_cache_if;
  logic [31:0] PC;
  logic        Flush;
  logic        Hit;
  logic [31:0] Instruction;
  logic        MemReq;
  logic [31:0] MemAddr;
  logic        MemValid;
  logic [31:0] MemData;

  modport master (
    output PC, Flush, MemValid, MemData,
    input  Hit, Instruction, MemReq, MemAddr
  );

  modport slave (
    input  PC, Flush, MemValid, MemData,
    output Hit, Instruction, MemReq, MemAddr
  );
endinterface

// File: rtl/instr_cache.sv
// Direct-mapped instruction cache with a combinational hit path.
// Misses are refilled one line at a time from an in-order beat stream.
//
// state  | meaning
// IDLE   | look up PC; on a miss, latch the line address and start a refill
// REFILL | take WORDS beats into the latched line; lookups are blocked
module instr_cache #(
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
  input logic           clk,
  input logic           rst_n,
  instr_cache_if.slave  bus
);

  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int LSB   = 2 + OFF_W;
  localparam int TAG_W = 32 - LSB - IDX_W;

  typedef enum logic {IDLE, REFILL} state_t;

  state_t             state, state_nxt;
  logic [LINES-1:0]   valid;
  logic [TAG_W-1:0]   tag_mem  [LINES];
  logic [31:0]        data_mem [LINES*WORDS];
  logic [OFF_W-1:0]   cnt;
  logic [IDX_W-1:0]   fill_idx;
  logic               drop;
  logic               mem_req;
  logic [31:0]        mem_addr;

  logic [OFF_W-1:0]   off;
  logic [IDX_W-1:0]   idx;
  logic [TAG_W-1:0]   tag;
  logic               lookup_hit;
  logic               start_fill;
  logic               beat_wr;
  logic               fill_done;
  logic               unused_pc;

  assign off       = bus.PC[LSB-1:2];
  assign idx       = bus.PC[LSB+IDX_W-1:LSB];
  assign tag       = bus.PC[31:LSB+IDX_W];
  assign unused_pc = ^bus.PC[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    lookup_hit = 1'b0;
    start_fill = 1'b0;
    beat_wr    = 1'b0;
    fill_done  = 1'b0;
    case (state)
      IDLE: begin
        lookup_hit = valid[idx] && (tag_mem[idx] == tag) && !bus.Flush;
        // A flush wins over a miss in the same cycle
        if (!bus.Flush && !lookup_hit) begin
          start_fill = 1'b1;
          state_nxt  = REFILL;
        end
      end
      REFILL: begin
        beat_wr = bus.MemValid;
        if (bus.MemValid && (cnt == OFF_W'(WORDS - 1))) begin
          fill_done = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.Hit         = lookup_hit;
  assign bus.Instruction = lookup_hit ? data_mem[{idx, off}] : 32'h0000_0000;
  assign bus.MemReq      = mem_req;
  assign bus.MemAddr     = mem_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid    <= '0;
      cnt      <= '0;
      fill_idx <= '0;
      drop     <= 1'b0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
    end else begin
      if (start_fill) begin
        mem_req  <= 1'b1;
        mem_addr <= {bus.PC[31:LSB], {LSB{1'b0}}};
        fill_idx <= idx;
        cnt      <= '0;
        drop     <= 1'b0;
      end
      if (beat_wr)   cnt     <= cnt + OFF_W'(1);
      if (fill_done) mem_req <= 1'b0;
      // A flush seen at any point of a refill keeps the finished line invalid
      if (state == REFILL && bus.Flush) drop <= 1'b1;
      if (bus.Flush)                    valid           <= '0;
      else if (start_fill)              valid[idx]      <= 1'b0;
      else if (fill_done && !drop)      valid[fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (start_fill) tag_mem[idx]               <= tag;
    if (beat_wr)    data_mem[{fill_idx, cnt}]  <= bus.MemData;
  end

endmodule

// File: tb/tb_instr_cache.sv
// Directed and random checks of instr_cache against a line-level cache model
// that tracks cached line addresses, fill progress and the flush/drop rules.
module tb_instr_cache;
  localparam int LINES  = 16;
  localparam int WORDS  = 4;
  localparam int LBYTES = 4 * WORDS;

  logic clk = 1'b0;
  logic rst_n;
  instr_cache_if bus ();

  instr_cache #(.LINES(LINES), .WORDS(WORDS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_fail = 0;
  int n_chk  = 0;

  bit          m_busy;
  bit          m_drop;
  int          m_beats;
  int          m_fidx;
  logic [31:0] m_fill_base;
  bit          m_valid [LINES];
  logic [31:0] m_line  [LINES];
  logic [31:0] m_data  [LINES][WORDS];

  function automatic int idx_of(input logic [31:0] a);
    return int'((a / 32'(LBYTES)) % 32'(LINES));
  endfunction

  function automatic int off_of(input logic [31:0] a);
    return int'((a / 32'd4) % 32'(WORDS));
  endfunction

  function automatic logic [31:0] base_of(input logic [31:0] a);
    return a - (a % 32'(LBYTES));
  endfunction

  function automatic bit model_hit(input logic [31:0] pc, input logic flush);
    int i;
    i = idx_of(pc);
    return !m_busy && m_valid[i] && (m_line[i] == base_of(pc)) && !flush;
  endfunction

  task automatic model_reset();
    m_busy  = 1'b0;
    m_drop  = 1'b0;
    m_beats = 0;
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check against the model, clock, advance the model.
  task automatic step(input logic [31:0] pc, input logic flush, input logic mv,
                      input logic [31:0] md);
    bit eh;
    bus.PC = pc; bus.Flush = flush; bus.MemValid = mv; bus.MemData = md;
    #1;
    eh = model_hit(pc, flush);
    chk("hit",    {31'b0, bus.Hit}, {31'b0, eh});
    chk("instr",  bus.Instruction, eh ? m_data[idx_of(pc)][off_of(pc)] : 32'h0);
    chk("memreq", {31'b0, bus.MemReq}, {31'b0, m_busy});
    if (m_busy) chk("memaddr", bus.MemAddr, m_fill_base);
    @(posedge clk);
    if (m_busy) begin
      if (flush) begin
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
        m_drop = 1'b1;
      end
      if (mv) begin
        m_data[m_fidx][m_beats] = md;
        m_beats++;
        if (m_beats == WORDS) begin
          m_busy = 1'b0;
          if (!m_drop) m_valid[m_fidx] = 1'b1;
        end
      end
    end else if (flush) begin
      for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    end else if (!eh) begin
      m_busy        = 1'b1;
      m_fill_base   = base_of(pc);
      m_fidx        = idx_of(pc);
      m_line[m_fidx]  = m_fill_base;
      m_valid[m_fidx] = 1'b0;
      m_beats       = 0;
      m_drop        = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic beats(input logic [31:0] pc, input logic [31:0] d0, input logic [31:0] stride);
    for (int i = 0; i < WORDS; i++) step(pc, 1'b0, 1'b1, d0 + stride * 32'(i));
  endtask

  // Lookup against fixed expectations without advancing the clock.
  task automatic peek(input string tag, input logic [31:0] pc, input logic eh,
                      input logic [31:0] ei);
    bus.PC = pc; bus.Flush = 1'b0; bus.MemValid = 1'b0;
    #1;
    chk({tag, "_hit"},   {31'b0, bus.Hit}, {31'b0, eh});
    chk({tag, "_instr"}, bus.Instruction, ei);
  endtask

  initial begin
    logic [31:0] pc;
    int          k;
    int          pat [7];

    rst_n = 1'b0;
    bus.PC = '0; bus.Flush = 1'b0; bus.MemValid = 1'b0; bus.MemData = '0;
    model_reset();
    #1;
    chk("rst_hit",     {31'b0, bus.Hit}, 32'h0);
    chk("rst_instr",   bus.Instruction, 32'h0);
    chk("rst_memreq",  {31'b0, bus.MemReq}, 32'h0);
    chk("rst_memaddr", bus.MemAddr, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Cold miss
    step(32'h40, 1'b0, 1'b0, 32'h0);
    chk("cold_memreq",  {31'b0, bus.MemReq}, 32'h1);
    chk("cold_memaddr", bus.MemAddr, 32'h40);
    beats(32'h40, 32'h11, 32'h11);
    peek("cold_w0", 32'h40, 1'b1, 32'h11);
    peek("cold_w1", 32'h44, 1'b1, 32'h22);
    step(32'h44, 1'b0, 1'b0, 32'h0);

    // Conflict on the same index
    step(32'h140, 1'b0, 1'b0, 32'h0);
    chk("conf_memaddr", bus.MemAddr, 32'h140);
    beats(32'h140, 32'hA0, 32'h1);
    peek("conf_new", 32'h14C, 1'b1, 32'hA3);
    peek("conf_old", 32'h40, 1'b0, 32'h0);
    step(32'h40, 1'b0, 1'b0, 32'h0);
    chk("conf_readdr", bus.MemAddr, 32'h40);
    beats(32'h40, 32'h11, 32'h11);

    // Beat gaps, with MemValid pulses in IDLE just before the miss
    step(32'h40, 1'b0, 1'b1, 32'hBAD0);
    step(32'h200, 1'b0, 1'b0, 32'h0);
    pat = '{1, 0, 1, 0, 0, 1, 1};
    k = 0;
    for (int i = 0; i < 7; i++) begin
      step(32'h200, 1'b0, pat[i] != 0, (pat[i] != 0) ? 32'hB0 + 32'(k) : 32'hDEAD);
      k += pat[i];
    end
    peek("gap_w0", 32'h200, 1'b1, 32'hB0);
    peek("gap_w1", 32'h204, 1'b1, 32'hB1);
    peek("gap_w2", 32'h208, 1'b1, 32'hB2);
    peek("gap_w3", 32'h20C, 1'b1, 32'hB3);

    // Flush together with a lookup: flush only, no refill
    step(32'h40, 1'b1, 1'b0, 32'h0);
    chk("flush_norefill", {31'b0, bus.MemReq}, 32'h0);
    // Flush during beat 2 of a refill
    step(32'h40, 1'b0, 1'b0, 32'h0);
    step(32'h40, 1'b0, 1'b1, 32'h11);
    step(32'h40, 1'b0, 1'b1, 32'h22);
    step(32'h40, 1'b1, 1'b1, 32'h33);
    step(32'h40, 1'b0, 1'b1, 32'h44);
    peek("flush_drop", 32'h40, 1'b0, 32'h0);
    step(32'h40, 1'b0, 1'b0, 32'h0);
    chk("flush_rereq", {31'b0, bus.MemReq}, 32'h1);
    beats(32'h40, 32'h11, 32'h11);

    // Reset in the middle of a refill
    step(32'h40, 1'b1, 1'b0, 32'h0);
    step(32'h40, 1'b0, 1'b0, 32'h0);
    step(32'h40, 1'b0, 1'b1, 32'h11);
    step(32'h40, 1'b0, 1'b1, 32'h22);
    rst_n = 1'b0;
    #1;
    chk("midrst_memreq",  {31'b0, bus.MemReq}, 32'h0);
    chk("midrst_memaddr", bus.MemAddr, 32'h0);
    chk("midrst_hit",     {31'b0, bus.Hit}, 32'h0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    peek("midrst_miss", 32'h40, 1'b0, 32'h0);
    step(32'h40, 1'b0, 1'b0, 32'h0);
    chk("midrst_readdr", bus.MemAddr, 32'h40);
    beats(32'h40, 32'h11, 32'h11);

    // PC redirect while refilling 0x40
    step(32'h40, 1'b1, 1'b0, 32'h0);
    step(32'h40, 1'b0, 1'b0, 32'h0);
    step(32'h40, 1'b0, 1'b1, 32'h11);
    beats(32'h80, 32'h22, 32'h11);
    step(32'h80, 1'b0, 1'b0, 32'h0);
    step(32'h80, 1'b0, 1'b0, 32'h0);
    chk("redir_memaddr", bus.MemAddr, 32'h80);
    beats(32'h80, 32'h55, 32'h1);
    peek("redir_old", 32'h40, 1'b1, 32'h11);
    peek("redir_new", 32'h84, 1'b1, 32'h56);

    // Random traffic over a few conflicting lines
    pc = 32'h0;
    repeat (600) begin
      if ($urandom_range(0, 9) < 3)
        pc = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 4) |
             (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      step(pc, $urandom_range(0, 29) == 0, $urandom_range(0, 9) < 6, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/instr_cache.md
INSTR_CACHE -- requirements
Module: instr_cache

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, with both ports named as listed below.
REQ-002 Parameter LINES, default 16: number of direct-mapped lines (power of two).
REQ-003 Parameter WORDS, default 4: 32-bit words per line (power of two); refill is WORDS beats.
REQ-004 Port clk  input  1  rising-edge clock.
REQ-005 Port rst_n  input  1  asynchronous active-low reset.
REQ-006 Port PC  input  32  fetch address from the Fetch stage; bits[1:0] ignored.
REQ-007 Port Flush  input  1  invalidate all lines.
REQ-008 Port Hit  output  1  Instruction is valid for the current PC.
REQ-009 Port Instruction  output  32  fetched word; 32'h00000000 (nop) when Hit=0.
REQ-010 Port MemReq  output  1  refill request to memory, held high for the whole refill.
REQ-011 Port MemAddr  output  32  line-aligned refill address, registered, stable while MemReq=1.
REQ-012 Port MemValid  input  1  MemData carries a valid refill beat this cycle.
REQ-013 Port MemData  input  32  refill data, one word per valid beat, in ascending word order.

Function
REQ-014 The address SHALL split as offset=PC[3:2], index=PC[7:4], tag=PC[31:8] at the defaults, with field widths derived from LINES and WORDS.
REQ-015 Storage SHALL hold per line: a valid bit, a tag, and WORDS data words.
REQ-016 The FSM SHALL have two states: IDLE and REFILL.
REQ-017 In IDLE, Hit SHALL be combinational: valid[index] AND tag match AND Flush=0; Instruction SHALL be the addressed word when Hit=1.
REQ-018 In REFILL, Hit SHALL be 0 and Instruction SHALL be 0 regardless of PC.
REQ-019 On a miss in IDLE with Flush=0, the next edge SHALL enter REFILL, set MemReq=1, load MemAddr={PC[31:4],4'b0}, clear valid[index], store the tag, and zero the beat counter.
REQ-020 In REFILL, each edge with MemValid=1 SHALL write MemData to word[counter] of the latched line and increment the counter; MemValid=0 SHALL hold the counter.
REQ-021 The edge that captures beat WORDS-1 SHALL set valid for the line (unless REQ-024 applies), drop MemReq, and return to IDLE.
REQ-022 When PC is unchanged, Hit SHALL assert in the first cycle after that edge; minimum miss penalty is WORDS+1 cycles.
REQ-023 A PC change during REFILL SHALL NOT abort or redirect the refill; the new PC is looked up on return to IDLE.
REQ-024 Flush in IDLE SHALL clear all valid bits at the next edge; Flush during REFILL SHALL clear all valid bits and set a drop flag so that the completing line is not validated.
REQ-025 MemValid in IDLE SHALL be ignored.
REQ-026 Flush and a miss in the same IDLE cycle SHALL perform the flush only; no refill starts that cycle.

Reset
REQ-027 While rst_n=0, outputs SHALL be immediately Hit=0, Instruction=0, MemReq=0, MemAddr=0, and the block SHALL be in state IDLE, with all valid bits 0, beat counter 0 and drop flag 0.
REQ-028 Reset asserted mid-refill SHALL abandon the refill; the partial line SHALL remain invalid.
REQ-029 Data and tag arrays need not be reset.

Verification
REQ-030 Cold miss: after reset, PC=0x40 -> next cycle MemReq=1, MemAddr=0x40; beats 0x11,0x22,0x33,0x44 -> Hit=1, Instruction=0x11; then PC=0x44 -> Hit=1, Instruction=0x22 in the same cycle.
REQ-031 Conflict: after REQ-030, PC=0x140 -> miss, MemAddr=0x140, refill with 0xA0..0xA3; then PC=0x40 -> Hit=0 and a new refill with MemAddr=0x40.
REQ-032 Beat gaps: MemValid pattern 1,0,1,0,0,1,1 -> exactly 4 words written in order; Hit asserts one cycle after the last valid beat.
REQ-033 Flush mid-refill: Flush pulses during beat 2 of a refill for 0x40 -> after completion PC=0x40 gives Hit=0 and MemReq re-asserts next cycle.
REQ-034 Reset mid-refill: rst_n=0 during beat 2 -> MemReq=0 immediately; after release, PC=0x40 misses again.
REQ-035 PC redirect: PC moves 0x40->0x80 during refill of 0x40 -> Hit stays 0; after completion 0x80 misses and MemAddr=0x80, and a later PC=0x40 hits.
